line_pair_feeder: RTL and testbench



---
 rtl/pipe_pkg.sv | 18 +
 rtl/line_pair_feeder_if.sv | 33 +++
 rtl/line_ram.sv | 34 +++
 rtl/line_pair_feeder.sv | 268 ++++++++++++++++++++++++++
 tb/tb_line_pair_feeder.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the bilinear upscale pipeline front-end:
// default geometry, pixel/counter widths and the line feeder FSM states.
package pipe_pkg;

    localparam int DEF_IMG_W = 1280;
    localparam int DEF_IMG_H = 720;
    localparam int DEF_DW    = 8;
    localparam int DEF_ROW_W = 11;
    localparam int DEF_COL_W = 11;

    typedef enum logic [1:0] {
        IDLE,
        LINE,
        GAP,
        FLUSH
    } state_t;

endpackage

// File: rtl/line_pair_feeder_if.sv
// Pixel stream bus of the line pair feeder: raster input from the source
// and the column-aligned previous/current line pair towards the
// column-interpolation stage.
interface line_pair_feeder_if #(
    parameter int DW    = pipe_pkg::DEF_DW,
    parameter int ROW_W = pipe_pkg::DEF_ROW_W
) ();

    logic             in_frame_start;
    logic             in_data_en;
    logic [DW-1:0]    in_data;
    logic [DW-1:0]    buf1_data_out;
    logic [DW-1:0]    buf2_data_out;
    logic             out_data_en;
    logic [ROW_W-1:0] row_cnt;
    logic             out_line_end;
    logic             err_len;

    // Pixel source and line-pair sink side.
    modport master (
        output in_frame_start, in_data_en, in_data,
        input  buf1_data_out, buf2_data_out, out_data_en, row_cnt,
               out_line_end, err_len
    );

    // Feeder side.
    modport slave (
        input  in_frame_start, in_data_en, in_data,
        output buf1_data_out, buf2_data_out, out_data_en, row_cnt,
               out_line_end, err_len
    );

endinterface

// File: rtl/line_ram.sv
// One line buffer bank: simple dual-port RAM with one write port and one
// registered read port (1-cycle read latency).
module line_ram
    import pipe_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int COL_W = DEF_COL_W
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [COL_W-1:0] i_waddr,
    input  logic [DW-1:0]    i_wdata,
    input  logic [COL_W-1:0] i_raddr,
    output logic [DW-1:0]    o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<COL_W)-1];
    logic [DW-1:0] r_rdata;

    // Store the incoming pixel at its column.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read of the addressed column.
    always_ff @(posedge clk) begin
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/line_pair_feeder.sv
// Line pair feeder: writes the raster stream into two ping-pong line RAMs
// and presents the previous and current line column-aligned, one clock
// after the input. Row 0 of each frame is top-edge replicated, line length
// and line count errors are flagged on a sticky err_len.
// Optional feature macro LPF_BOTTOM_FLUSH_EN: after the last line of the
// frame, replay that line once more (bottom-edge replication) with
// row_cnt = IMG_H.
module line_pair_feeder
    import pipe_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int DW    = DEF_DW,
    parameter int ROW_W = DEF_ROW_W,
    parameter int COL_W = DEF_COL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    line_pair_feeder_if.slave bus
);

    // One extra bit so the write column can hold IMG_W without wrapping.
    localparam int CW = COL_W + 1;
    localparam logic [CW-1:0]    LP_W   = CW'(IMG_W);
    localparam logic [CW-1:0]    LP_WM1 = CW'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LP_HM1 = ROW_W'(IMG_H - 1);
`ifdef LPF_BOTTOM_FLUSH_EN
    localparam logic [ROW_W-1:0] LP_H   = ROW_W'(IMG_H);
`endif

    state_t           r_state;
    logic [CW-1:0]    r_wr_col;
    logic             r_bank;
    logic [ROW_W-1:0] r_row;
    logic             r_last_done;
    logic             r_de_d;

    logic             r_out_de;
    logic             r_line_end;
    logic             r_err;
    logic             r_rep;
    logic             r_rd_sel;
    logic [DW-1:0]    r_buf2;
    logic [ROW_W-1:0] r_row_out;

`ifdef LPF_BOTTOM_FLUSH_EN
    logic [CW-1:0]    r_fl_col;
    logic             r_flushed;
    logic             r_fl_out;
`endif

    logic             w_fs;
    logic             w_de;
    logic             w_bank;
    logic [CW-1:0]    w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_in_range;
    logic             w_flush_go;
    logic             w_in_flush;
    logic             w_open;
    logic             w_pix;
    logic             w_ovf;
    logic             w_fall;
    logic             w_extra;
    logic             w_short;
    logic             w_flerr;
    logic             w_err_set;
    logic [COL_W-1:0] w_rd_addr;
    logic             w_we0;
    logic             w_we1;
    logic [DW-1:0]    w_q0;
    logic [DW-1:0]    w_q1;
    logic [DW-1:0]    w_q;
    logic [DW-1:0]    w_buf2;

    assign w_fs = bus.in_frame_start;
    assign w_de = bus.in_data_en;

    // A frame start overrides the bookkeeping so a coincident pixel lands
    // in column 0 of row 0, bank 0.
    assign w_bank     = w_fs ? 1'b0 : r_bank;
    assign w_col      = w_fs ? '0   : r_wr_col;
    assign w_row      = w_fs ? '0   : r_row;
    assign w_in_range = (w_col < LP_W);

`ifdef LPF_BOTTOM_FLUSH_EN
    assign w_flush_go = (r_state == GAP) && r_last_done && !r_flushed;
    assign w_in_flush = (r_state == FLUSH);
    assign w_rd_addr  = (w_in_flush && !w_fs) ? r_fl_col[COL_W-1:0]
                                              : w_col[COL_W-1:0];
`else
    assign w_flush_go = 1'b0;
    assign w_in_flush = 1'b0;
    assign w_rd_addr  = w_col[COL_W-1:0];
`endif

    // After reset a line that was already running is ignored until
    // in_data_en drops (r_de_d resets high), so a cut line emits nothing.
    assign w_open = w_fs
                 || (r_state == LINE)
                 || ((r_state == GAP) && !w_flush_go)
                 || ((r_state == IDLE) && !r_de_d);

    assign w_pix     = w_de && w_open && w_in_range;
    assign w_ovf     = w_de && w_open && !w_in_range;
    assign w_fall    = !w_fs && (r_state == LINE) && !w_de;
    assign w_extra   = w_pix && !w_fs && r_last_done;
    assign w_short   = w_fall && (r_wr_col != LP_W);
    assign w_flerr   = w_de && !w_fs && (w_in_flush || w_flush_go);
    assign w_err_set = w_ovf || w_extra || w_short || w_flerr;

    assign w_we0 = rst_n && w_pix && !w_bank;
    assign w_we1 = rst_n && w_pix &&  w_bank;

    line_ram #(
        .DW    (DW),
        .COL_W (COL_W)
    ) u_ram0 (
        .clk     (clk),
        .i_we    (w_we0),
        .i_waddr (w_col[COL_W-1:0]),
        .i_wdata (bus.in_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_q0)
    );

    line_ram #(
        .DW    (DW),
        .COL_W (COL_W)
    ) u_ram1 (
        .clk     (clk),
        .i_we    (w_we1),
        .i_waddr (w_col[COL_W-1:0]),
        .i_wdata (bus.in_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_q1)
    );

    // Read data comes from the bank not being written this line.
    assign w_q = r_rd_sel ? w_q1 : w_q0;

`ifdef LPF_BOTTOM_FLUSH_EN
    assign w_buf2 = r_fl_out ? w_q : r_buf2;
`else
    assign w_buf2 = r_buf2;
`endif

    assign bus.buf1_data_out = r_rep ? w_buf2 : w_q;
    assign bus.buf2_data_out = w_buf2;
    assign bus.out_data_en   = r_out_de;
    assign bus.row_cnt       = r_row_out;
    assign bus.out_line_end  = r_line_end;
    assign bus.err_len       = r_err;

    // Line FSM plus write/row bookkeeping and the registered output stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_wr_col    <= '0;
            r_bank      <= 1'b0;
            r_row       <= '0;
            r_last_done <= 1'b0;
            r_de_d      <= 1'b1;
            r_out_de    <= 1'b0;
            r_line_end  <= 1'b0;
            r_err       <= 1'b0;
            r_rep       <= 1'b1;
            r_rd_sel    <= 1'b0;
            r_buf2      <= '0;
            r_row_out   <= '0;
`ifdef LPF_BOTTOM_FLUSH_EN
            r_fl_col    <= '0;
            r_flushed   <= 1'b0;
            r_fl_out    <= 1'b0;
`endif
        end else begin
            r_de_d     <= w_de;
            r_out_de   <= w_pix;
            r_line_end <= w_pix && (w_col == LP_WM1);
            r_rd_sel   <= ~w_bank;

            if (w_pix) begin
                r_buf2    <= bus.in_data;
                r_rep     <= (w_row == '0);
                r_row_out <= w_row;
                r_wr_col  <= w_col + 1'b1;
`ifdef LPF_BOTTOM_FLUSH_EN
                r_fl_out  <= 1'b0;
`endif
            end

            if (w_fs) begin
                r_err       <= 1'b0;
                r_bank      <= 1'b0;
                r_row       <= '0;
                r_last_done <= 1'b0;
`ifdef LPF_BOTTOM_FLUSH_EN
                r_flushed   <= 1'b0;
`endif
                if (!w_pix) begin
                    r_wr_col <= '0;
                end
            end else begin
                r_err <= r_err || w_err_set;
            end

            if (w_fall) begin
                r_bank   <= ~r_bank;
                r_wr_col <= '0;
                if (r_row == LP_HM1) begin
                    r_last_done <= 1'b1;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end

            if (w_fs) begin
                r_state <= w_de ? LINE : IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_de && !r_de_d) begin
                            r_state <= LINE;
                        end
                    end
                    LINE: begin
                        if (!w_de) begin
                            r_state <= GAP;
                        end
                    end
                    GAP: begin
`ifdef LPF_BOTTOM_FLUSH_EN
                        if (w_flush_go) begin
                            r_state   <= FLUSH;
                            r_fl_col  <= '0;
                            r_flushed <= 1'b1;
                        end else if (w_de) begin
                            r_state <= LINE;
                        end
`else
                        if (w_de) begin
                            r_state <= LINE;
                        end
`endif
                    end
`ifdef LPF_BOTTOM_FLUSH_EN
                    FLUSH: begin
                        r_out_de   <= 1'b1;
                        r_line_end <= (r_fl_col == LP_WM1);
                        r_fl_out   <= 1'b1;
                        r_rep      <= 1'b0;
                        r_row_out  <= LP_H;
                        if (r_fl_col == LP_WM1) begin
                            r_state <= IDLE;
                        end else begin
                            r_fl_col <= r_fl_col + 1'b1;
                        end
                    end
`endif
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_line_pair_feeder.sv
// Directed bench for line_pair_feeder at IMG_W=8, IMG_H=4. Pixels are
// driven 1 ns after a rising edge and outputs sampled 1 ns after the next
// rising edge, which is exactly the 1-clock output latency. Observed
// outputs are packed as {out_data_en, out_line_end, err_len, row_cnt,
// buf1, buf2}. Honours LPF_BOTTOM_FLUSH_EN like the design.
module tb_line_pair_feeder;

    localparam int W     = 8;
    localparam int H     = 4;
    localparam int DW    = 8;
    localparam int ROW_W = 11;
    localparam int COL_W = 3;
    localparam int OW    = 3 + ROW_W + 2 * DW;

    typedef logic [OW-1:0] obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   nTests = 0;
    int   nFail  = 0;

    line_pair_feeder_if #(.DW(DW), .ROW_W(ROW_W)) bus ();

    line_pair_feeder #(
        .IMG_W (W),
        .IMG_H (H),
        .DW    (DW),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Pack the current output values for comparison.
    function automatic obs_t obs();
        return {bus.out_data_en, bus.out_line_end, bus.err_len, bus.row_cnt,
                bus.buf1_data_out, bus.buf2_data_out};
    endfunction

    // Drive one input cycle and move to just after the edge that samples it.
    task automatic applyStimulus(input logic fs, input logic de, input logic [DW-1:0] d);
        bus.in_frame_start = fs;
        bus.in_data_en     = de;
        bus.in_data        = d;
        @(posedge clk);
        #1;
    endtask

    task automatic driveLine(input int row, input int n, input logic fsFirst);
        for (int c = 0; c < n; c++) begin
            applyStimulus(fsFirst && (c == 0), 1'b1, DW'(16 * row + c));
        end
    endtask

    task automatic driveGap(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, '0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'hA5);
        nTests++;
        if (obs() !== '0) begin
            nFail++;
            $display("[TB] FAIL reset_hold got=%h exp=0", obs());
        end
        rst_n = 1'b1;
        driveGap(2);
        nTests++;
        if (obs() !== '0) begin
            nFail++;
            $display("[TB] FAIL reset_idle got=%h exp=0", obs());
        end
    endtask

    task automatic test_frame();
        obs_t expV;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                applyStimulus((r == 0) && (c == 0), 1'b1, DW'(16 * r + c));
                expV = {1'b1, (c == W - 1), 1'b0, ROW_W'(r),
                        DW'((r == 0) ? (16 * r + c) : (16 * (r - 1) + c)),
                        DW'(16 * r + c)};
                nTests++;
                if (obs() !== expV) begin
                    nFail++;
                    $display("[TB] FAIL frame r%0d c%0d got=%h exp=%h", r, c, obs(), expV);
                end
            end
            applyStimulus(1'b0, 1'b0, '0);
            nTests++;
            if ({bus.out_data_en, bus.out_line_end} !== 2'b00) begin
                nFail++;
                $display("[TB] FAIL frame_gap r%0d de/le got=%b exp=00", r,
                         {bus.out_data_en, bus.out_line_end});
            end
            applyStimulus(1'b0, 1'b0, '0);
        end
`ifdef LPF_BOTTOM_FLUSH_EN
        for (int c = 0; c < W; c++) begin
            applyStimulus(1'b0, 1'b0, '0);
            expV = {1'b1, (c == W - 1), 1'b0, ROW_W'(H), DW'(48 + c), DW'(48 + c)};
            nTests++;
            if (obs() !== expV) begin
                nFail++;
                $display("[TB] FAIL flush c%0d got=%h exp=%h", c, obs(), expV);
            end
        end
        applyStimulus(1'b0, 1'b0, '0);
        nTests++;
        if (bus.out_data_en !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL flush_end de got=%b exp=0", bus.out_data_en);
        end
`else
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, '0);
            nTests++;
            if (bus.out_data_en !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL no_flush cyc%0d de got=%b exp=0", i, bus.out_data_en);
            end
        end
`endif
    endtask

    task automatic test_short_line();
        obs_t expV;
        driveLine(0, W, 1'b1);
        driveGap(2);
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b0, 1'b1, DW'(16 + c));
            expV = {1'b1, 1'b0, 1'b0, ROW_W'(1), DW'(c), DW'(16 + c)};
            nTests++;
            if (obs() !== expV) begin
                nFail++;
                $display("[TB] FAIL short c%0d got=%h exp=%h", c, obs(), expV);
            end
        end
        applyStimulus(1'b0, 1'b0, '0);
        nTests++;
        if ({bus.out_data_en, bus.err_len} !== 2'b01) begin
            nFail++;
            $display("[TB] FAIL short_err de/err got=%b exp=01", {bus.out_data_en, bus.err_len});
        end
        applyStimulus(1'b0, 1'b0, '0);
    endtask

    task automatic test_frame_clear();
        obs_t expV;
        for (int c = 0; c < W; c++) begin
            applyStimulus(c == 0, 1'b1, DW'(8'h70 + c));
            expV = {1'b1, (c == W - 1), 1'b0, ROW_W'(0), DW'(8'h70 + c), DW'(8'h70 + c)};
            nTests++;
            if (obs() !== expV) begin
                nFail++;
                $display("[TB] FAIL clear c%0d got=%h exp=%h", c, obs(), expV);
            end
        end
        driveGap(2);
    endtask

    task automatic test_long_line();
        obs_t expV;
        driveLine(0, W, 1'b1);
        driveGap(2);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, 1'b1, DW'(16 + c));
            if (c < W) begin
                expV = {1'b1, (c == W - 1), 1'b0, ROW_W'(1), DW'(c), DW'(16 + c)};
                nTests++;
                if (obs() !== expV) begin
                    nFail++;
                    $display("[TB] FAIL long c%0d got=%h exp=%h", c, obs(), expV);
                end
            end else begin
                nTests++;
                if ({bus.out_data_en, bus.err_len} !== 2'b01) begin
                    nFail++;
                    $display("[TB] FAIL long_ovf c%0d de/err got=%b exp=01", c,
                             {bus.out_data_en, bus.err_len});
                end
            end
        end
        driveGap(2);
        for (int c = 0; c < W; c++) begin
            applyStimulus(1'b0, 1'b1, DW'(32 + c));
            expV = {1'b1, (c == W - 1), 1'b1, ROW_W'(2), DW'(16 + c), DW'(32 + c)};
            nTests++;
            if (obs() !== expV) begin
                nFail++;
                $display("[TB] FAIL long_next c%0d got=%h exp=%h", c, obs(), expV);
            end
        end
        driveGap(2);
    endtask

    task automatic test_midframe_start();
        obs_t expV;
        driveLine(0, W, 1'b1);
        driveGap(2);
        driveLine(1, W, 1'b0);
        driveGap(2);
        for (int c = 0; c < W; c++) begin
            applyStimulus(c == 0, 1'b1, DW'(8'hC0 + c));
            expV = {1'b1, (c == W - 1), 1'b0, ROW_W'(0), DW'(8'hC0 + c), DW'(8'hC0 + c)};
            nTests++;
            if (obs() !== expV) begin
                nFail++;
                $display("[TB] FAIL midfs c%0d got=%h exp=%h", c, obs(), expV);
            end
        end
        driveGap(2);
        for (int c = 0; c < W; c++) begin
            applyStimulus(1'b0, 1'b1, DW'(8'hD0 + c));
            expV = {1'b1, (c == W - 1), 1'b0, ROW_W'(1), DW'(8'hC0 + c), DW'(8'hD0 + c)};
            nTests++;
            if (obs() !== expV) begin
                nFail++;
                $display("[TB] FAIL midfs_next c%0d got=%h exp=%h", c, obs(), expV);
            end
        end
        driveGap(2);
    endtask

    task automatic test_reset_midline();
        obs_t expV;
        driveLine(0, W, 1'b1);
        driveGap(2);
        driveLine(1, 4, 1'b0);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1, DW'(20));
        nTests++;
        if (obs() !== '0) begin
            nFail++;
            $display("[TB] FAIL rst_mid got=%h exp=0", obs());
        end
        rst_n = 1'b1;
        for (int c = 5; c < W; c++) begin
            applyStimulus(1'b0, 1'b1, DW'(16 + c));
            nTests++;
            if (bus.out_data_en !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL rst_tail c%0d de got=%b exp=0", c, bus.out_data_en);
            end
        end
        driveGap(2);
        for (int c = 0; c < W; c++) begin
            applyStimulus(c == 0, 1'b1, DW'(8'h90 + c));
            expV = {1'b1, (c == W - 1), 1'b0, ROW_W'(0), DW'(8'h90 + c), DW'(8'h90 + c)};
            nTests++;
            if (obs() !== expV) begin
                nFail++;
                $display("[TB] FAIL rst_row0 c%0d got=%h exp=%h", c, obs(), expV);
            end
        end
        driveGap(2);
        for (int c = 0; c < W; c++) begin
            applyStimulus(1'b0, 1'b1, DW'(8'hA0 + c));
            expV = {1'b1, (c == W - 1), 1'b0, ROW_W'(1), DW'(8'h90 + c), DW'(8'hA0 + c)};
            nTests++;
            if (obs() !== expV) begin
                nFail++;
                $display("[TB] FAIL rst_row1 c%0d got=%h exp=%h", c, obs(), expV);
            end
        end
        driveGap(2);
    endtask

    // Run every scenario in order, then report.
    initial begin
        bus.in_frame_start = 1'b0;
        bus.in_data_en     = 1'b0;
        bus.in_data        = '0;
        test_reset();
        test_frame();
        test_short_line();
        test_frame_clear();
        test_long_line();
        test_midframe_start();
        test_reset_midline();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
